fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch control for the pipelined RV32I core. Drives pc_next into the PC register and
//  issues one instruction-memory request at a time over a valid/ready handshake. Captures the response
//  into the IF/ID pipeline register, including its valid bit, with a 1-entry skid buffer.
//  Also absorbs decode stalls and EX-stage redirects (branch/jump), squashing wrong-path instructions.
// PARAMETERS
//  RESET_PC  32'h0000_0000  value driven on pc_next while reset is high; matches the PC register reset value
//  NOP_INSTR 32'h0000_0013  encoding (addi x0,x0,0) loaded into ifid_instr on reset and on bubble
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   synchronous, active-high
//  pc             in   32  current PC from PC register
//  pc_next        out  32  next PC into PC register (combinational)
//  imem_req_valid out  1   fetch request valid
//  imem_req_ready in   1   imem accepts request this cycle
//  imem_req_addr  out  32  request address (= pc)
//  imem_rsp_valid in   1   response valid; at earliest the cycle after acceptance
//  imem_rsp_data  in   32  instruction word
//  stall_d        in   1   hazard unit: decode cannot consume IF/ID this cycle
//  redirect_valid in   1   EX: control-flow redirect
//  redirect_pc    in   32  redirect target
//  ifid_valid     out  1   IF/ID holds a real instruction
//  ifid_pc        out  32  PC of ifid_instr
//  ifid_instr     out  32  instruction to decode
//  ifid_pc_plus4  out  32  ifid_pc + 4, modulo 2^32
// BEHAVIOUR
//  Reset (registered): state=REQ, ifid_valid=0, ifid_pc=0, ifid_pc_plus4=4, ifid_instr=NOP_INSTR,
//   skid buffer empty. While reset is high: pc_next=RESET_PC, imem_req_valid=0.
//  Internal req_pc register: holds the address of the outstanding request, latched on acceptance.
//  IF/ID accepts a new entry when (!ifid_valid || !stall_d).
//   - If accepting with nothing to load: ifid_valid<=0 and ifid_instr<=NOP_INSTR (bubble).
//   - stall_d && ifid_valid: all IF/ID fields hold.
//  FSM (one outstanding request max; pc_next=pc unless stated):
//   REQ : imem_req_valid=1, imem_req_addr=pc. On valid&&ready: req_pc<=pc, pc_next=pc+4, ->WAIT.
//   WAIT: imem_req_valid=0. On rsp_valid:
//         - if IF/ID accepts: load {req_pc, rsp_data}, valid=1, ->REQ.
//         - else: write skid buffer, ->HOLD.
//   HOLD: imem_req_valid=0. When IF/ID accepts: move buffer to IF/ID, empty buffer, ->REQ.
//   DROP: imem_req_valid=0. Waits for the squashed response, discards it, ->REQ.
//  Redirect (redirect_valid=1) has highest priority, in any state:
//   - pc_next=redirect_pc; ifid_valid<=0, ifid_instr<=NOP_INSTR; skid buffer emptied; stall_d ignored.
//   - REQ without accept: ->REQ. REQ with accept same cycle: ->DROP.
//   - WAIT without rsp: ->DROP. WAIT with rsp same cycle: rsp discarded, ->REQ.
//   - HOLD: ->REQ.
//   - DROP without rsp: stay DROP, new target taken. DROP with rsp: ->REQ.
//  Latency: accept at cycle N, rsp at N+k (k>=1), ifid_valid visible at N+k+1.
//   Back-to-back fetch with k=1 gives one instruction per 2 cycles.
//  Arithmetic: pc+4 and ifid_pc_plus4 wrap modulo 2^32 (pc=32'hFFFF_FFFC -> 0). No alignment check.
//  Reset mid-operation: any outstanding response arriving after reset is ignored (state REQ does not
//   sample imem_rsp_valid).
// TESTING
//  1 reset 2 cyc, ready=1, rsp k=1 -> req addrs 0,4,8; ifid_pc 0,4,8 with valid; pc_plus4 4,8,12.
//  2 stall_d=1 for 4 cyc while ifid holds pc=4 -> ifid holds; pc=8 rsp goes to HOLD,
//    no new request; release -> ifid_pc=8 next cycle.
//  3 redirect_pc=0x100 in WAIT (req 0x8) -> DROP; 0x8 rsp discarded; next req addr 0x100;
//    ifid_valid=0 until 0x100 rsp.
//  4 redirect same cycle as rsp in WAIT -> rsp dropped, state REQ, next req 0x100.
//  5 imem_req_ready=0 for 3 cyc -> req_valid held, addr stable, pc_next=pc.
//  6 pc=0xFFFF_FFFC accepted -> pc_next=0; ifid_pc_plus4=0. Reset asserted in WAIT -> ifid_valid=0,
//    late rsp ignored.

Source files
------------

// File: rtl/fetch_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_stage_if : instruction-memory request/response bundle        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface fetch_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_stage : RV32I fetch control, one outstanding imem request,   |
// |               IF/ID register with 1-entry skid, redirect squashing |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic [31:0] pc_i,
  output logic      [31:0] pc_next_o,
  fetch_stage_if.master    imem,
  input  wire logic        stall_d_i,
  input  wire logic        redirect_valid_i,
  input  wire logic [31:0] redirect_pc_i,
  output logic             ifid_valid_o,
  output logic      [31:0] ifid_pc_o,
  output logic      [31:0] ifid_instr_o,
  output logic      [31:0] ifid_pc_plus4_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] req_pc_q;
  logic        skid_valid_q;
  logic [31:0] skid_pc_q;
  logic [31:0] skid_instr_q;
  logic        ifid_valid_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_instr_q;
  logic [31:0] ifid_pc_plus4_q;

  logic        req_valid;
  logic        req_fire;
  logic        ifid_take;

  assign req_valid = (state_q == S_REQ) && !reset;
  assign req_fire  = req_valid && imem.req_ready;
  assign ifid_take = !ifid_valid_q || !stall_d_i;

  assign imem.req_valid = req_valid;
  assign imem.req_addr  = pc_i;

  always_comb begin
    pc_next_o = pc_i;
    if (reset) begin
      pc_next_o = RESET_PC;
    end else if (redirect_valid_i) begin
      pc_next_o = redirect_pc_i;
    end else if (req_fire) begin
      pc_next_o = pc_i + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_REQ;
      req_pc_q        <= 32'h0;
      skid_valid_q    <= 1'b0;
      skid_pc_q       <= 32'h0;
      skid_instr_q    <= NOP_INSTR;
      ifid_valid_q    <= 1'b0;
      ifid_pc_q       <= 32'h0;
      ifid_instr_q    <= NOP_INSTR;
      ifid_pc_plus4_q <= 32'd4;
    end else if (redirect_valid_i) begin
      // Wrong-path flush: whatever is in flight or buffered is discarded.
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      skid_valid_q <= 1'b0;
      unique case (state_q)
        S_REQ: begin
          if (req_fire) begin
            req_pc_q <= pc_i;
            state_q  <= S_DROP;
          end
        end
        S_WAIT:  state_q <= imem.rsp_valid ? S_REQ : S_DROP;
        S_HOLD:  state_q <= S_REQ;
        S_DROP:  state_q <= imem.rsp_valid ? S_REQ : S_DROP;
        default: state_q <= S_REQ;
      endcase
    end else begin
      // Bubble by default whenever IF/ID can advance; a load below overrides it.
      if (ifid_take) begin
        ifid_valid_q <= 1'b0;
        ifid_instr_q <= NOP_INSTR;
      end
      unique case (state_q)
        S_REQ: begin
          if (req_fire) begin
            req_pc_q <= pc_i;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.rsp_valid) begin
            if (ifid_take) begin
              ifid_valid_q    <= 1'b1;
              ifid_pc_q       <= req_pc_q;
              ifid_instr_q    <= imem.rsp_data;
              ifid_pc_plus4_q <= req_pc_q + 32'd4;
              state_q         <= S_REQ;
            end else begin
              skid_valid_q <= 1'b1;
              skid_pc_q    <= req_pc_q;
              skid_instr_q <= imem.rsp_data;
              state_q      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (ifid_take) begin
            ifid_valid_q    <= 1'b1;
            ifid_pc_q       <= skid_pc_q;
            ifid_instr_q    <= skid_instr_q;
            ifid_pc_plus4_q <= skid_pc_q + 32'd4;
            skid_valid_q    <= 1'b0;
            state_q         <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem.rsp_valid) begin
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  assign ifid_valid_o    = ifid_valid_q;
  assign ifid_pc_o       = ifid_pc_q;
  assign ifid_instr_o    = ifid_instr_q;
  assign ifid_pc_plus4_o = ifid_pc_plus4_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_stage : directed bench with a transaction-level model     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        stall_d;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;

  fetch_stage_if mem ();

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_i            (pc),
    .pc_next_o       (pc_next),
    .imem            (mem),
    .stall_d_i       (stall_d),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .ifid_valid_o    (ifid_valid),
    .ifid_pc_o       (ifid_pc),
    .ifid_instr_o    (ifid_instr),
    .ifid_pc_plus4_o (ifid_pc_plus4)
  );

  always #5 clk = ~clk;

  // PC register owned by the core
  always @(posedge clk) pc <= pc_next;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  // Instruction memory: fixed latency per request, one-cycle response pulse.
  typedef struct {logic [31:0] addr; int due;} pend_t;
  pend_t       pend[$];
  logic [31:0] acc_log[$];
  int          cyc = 0;
  int          lat = 1;

  always begin
    @(posedge clk);
    if (mem.rsp_valid && pend.size() > 0) void'(pend.pop_front());
    if (mem.req_valid && mem.req_ready) begin
      pend.push_back('{addr: mem.req_addr, due: cyc + lat});
      acc_log.push_back(mem.req_addr);
    end
    cyc++;
    #1;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      mem.rsp_valid = 1'b1;
      mem.rsp_data  = word_at(pend[0].addr);
    end else begin
      mem.rsp_valid = 1'b0;
      mem.rsp_data  = 32'hDEAD_BEEF;
    end
  end

  // Model: an outstanding-request flag, a squash flag, a skid slot and the IF/ID contents.
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  bit          m_live = 1'b0;
  bit          m_out, m_sq, m_skf;
  ent_t        m_ske;
  logic [31:0] m_rpc;
  logic        m_ifv;
  logic [31:0] m_ifpc, m_ifi;

  always @(posedge clk) begin
    bit          out_n, sq_n, sk_n, issue, live_rsp, take, have_new;
    ent_t        ske_n, nw;
    logic        ifv_n;
    logic [31:0] ifpc_n, ifi_n, rpc_n;
    out_n = m_out; sq_n = m_sq; sk_n = m_skf; ske_n = m_ske;
    ifv_n = m_ifv; ifpc_n = m_ifpc; ifi_n = m_ifi; rpc_n = m_rpc;
    have_new = 1'b0; nw = '{pc: 32'h0, instr: 32'h0};
    issue    = !m_out && !m_skf && mem.req_ready;
    live_rsp = mem.rsp_valid && m_out;
    take     = !m_ifv || !stall_d;
    if (reset) begin
      out_n = 0; sq_n = 0; sk_n = 0; ifv_n = 0; ifpc_n = 32'h0; ifi_n = NOP_INSTR;
    end else if (redirect_valid) begin
      ifv_n = 0; ifi_n = NOP_INSTR; sk_n = 0;
      if (live_rsp) begin out_n = 0; sq_n = 0; end
      else if (m_out) sq_n = 1;
      if (issue) begin out_n = 1; sq_n = 1; rpc_n = pc; end
    end else begin
      if (live_rsp) begin
        out_n = 0; sq_n = 0;
        if (!m_sq) begin have_new = 1; nw = '{pc: m_rpc, instr: mem.rsp_data}; end
      end
      if (take) begin
        if (m_skf) begin ifv_n = 1; ifpc_n = m_ske.pc; ifi_n = m_ske.instr; sk_n = 0; end
        else if (have_new) begin ifv_n = 1; ifpc_n = nw.pc; ifi_n = nw.instr; end
        else begin ifv_n = 0; ifi_n = NOP_INSTR; end
      end else if (have_new) begin
        sk_n = 1; ske_n = nw;
      end
      if (issue) begin out_n = 1; sq_n = 0; rpc_n = pc; end
    end
    m_out <= out_n; m_sq <= sq_n; m_skf <= sk_n; m_ske <= ske_n; m_rpc <= rpc_n;
    m_ifv <= ifv_n; m_ifpc <= ifpc_n; m_ifi <= ifi_n;
    if (reset) m_live <= 1'b1;
  end

  always @(negedge clk) begin
    logic        exp_rv;
    logic [31:0] exp_pn;
    if (m_live) begin
      exp_rv = !reset && !m_out && !m_skf;
      exp_pn = reset ? RESET_PC : redirect_valid ? redirect_pc :
               (exp_rv && mem.req_ready) ? pc + 32'd4 : pc;
      chk("m.req_valid", mem.req_valid, exp_rv);
      chk("m.pc_next", pc_next, exp_pn);
      if (exp_rv) chk("m.req_addr", mem.req_addr, pc);
      chk("m.ifid_valid", ifid_valid, m_ifv);
      chk("m.ifid_pc", ifid_pc, m_ifpc);
      chk("m.ifid_pc_plus4", ifid_pc_plus4, m_ifpc + 32'd4);
      chk("m.ifid_instr", ifid_instr, m_ifi);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycles(1);
    reset = 1'b1; stall_d = 1'b0; redirect_valid = 1'b0;
    cycles(2);
    reset = 1'b0;
    acc_log.delete();
  endtask

  task automatic wait_ifid(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ifid_valid) break;
    end
    if (i == budget) chk({name, ".timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall_d = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    mem.req_ready = 1'b1; mem.rsp_valid = 1'b0; mem.rsp_data = 32'h0;
    cycles(1);
    @(negedge clk);
    chk("rst.ifid_valid", ifid_valid, 32'd0);
    chk("rst.ifid_pc", ifid_pc, 32'h0);
    chk("rst.ifid_pc_plus4", ifid_pc_plus4, 32'd4);
    chk("rst.ifid_instr", ifid_instr, NOP_INSTR);
    chk("rst.req_valid", mem.req_valid, 32'd0);
    chk("rst.pc_next", pc_next, RESET_PC);

    // Back-to-back fetch, k=1
    lat = 1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wait_ifid("t1", 20);
      chk("t1.ifid_pc", ifid_pc, 32'(4 * i));
      chk("t1.ifid_pc_plus4", ifid_pc_plus4, 32'(4 * i + 4));
      chk("t1.ifid_instr", ifid_instr, word_at(32'(4 * i)));
    end
    chk("t1.n_req", 32'(acc_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < acc_log.size(); i++) chk("t1.req_addr", acc_log[i], 32'(4 * i));

    // Decode stall with skid fill and release
    do_reset();
    cycles(4);
    stall_d = 1'b1;
    cycles(2);
    @(negedge clk);
    chk("t2.req_valid_hold", mem.req_valid, 32'd0);
    chk("t2.ifid_pc_held", ifid_pc, 32'd4);
    chk("t2.ifid_valid_held", ifid_valid, 32'd1);
    cycles(2);
    stall_d = 1'b0;
    @(negedge clk);
    chk("t2.ifid_pc_release", ifid_pc, 32'd4);
    cycles(1);
    @(negedge clk);
    chk("t2.ifid_pc_next", ifid_pc, 32'd8);
    chk("t2.ifid_instr_next", ifid_instr, word_at(32'd8));

    // Redirect in WAIT without response, k=2
    lat = 2;
    do_reset();
    cycles(7);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    chk("t3.pc_next", pc_next, 32'h100);
    cycles(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t3.drop_req_valid", mem.req_valid, 32'd0);
    chk("t3.drop_ifid_valid", ifid_valid, 32'd0);
    cycles(1);
    @(negedge clk);
    chk("t3.req_valid", mem.req_valid, 32'd1);
    chk("t3.req_addr", mem.req_addr, 32'h100);
    wait_ifid("t3", 20);
    chk("t3.ifid_pc", ifid_pc, 32'h100);
    chk("t3.ifid_instr", ifid_instr, word_at(32'h100));

    // Redirect coincident with the response
    lat = 1;
    do_reset();
    cycles(1);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cycles(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t4.req_valid", mem.req_valid, 32'd1);
    chk("t4.req_addr", mem.req_addr, 32'h100);
    chk("t4.ifid_valid", ifid_valid, 32'd0);
    wait_ifid("t4", 20);
    chk("t4.ifid_pc", ifid_pc, 32'h100);

    // imem back-pressure
    mem.req_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5.req_valid", mem.req_valid, 32'd1);
      chk("t5.req_addr", mem.req_addr, 32'h0);
      chk("t5.pc_next", pc_next, 32'h0);
      cycles(1);
    end
    mem.req_ready = 1'b1;
    wait_ifid("t5", 20);
    chk("t5.ifid_pc", ifid_pc, 32'h0);

    // Address wrap, then reset while a request is outstanding
    do_reset();
    mem.req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("t6.redir_pc_next", pc_next, 32'hFFFF_FFFC);
    cycles(1);
    mem.req_ready = 1'b1; redirect_valid = 1'b0;
    @(negedge clk);
    chk("t6.req_addr", mem.req_addr, 32'hFFFF_FFFC);
    chk("t6.pc_next_wrap", pc_next, 32'h0);
    cycles(2);
    lat = 2;
    @(negedge clk);
    chk("t6.ifid_pc", ifid_pc, 32'hFFFF_FFFC);
    chk("t6.ifid_pc_plus4", ifid_pc_plus4, 32'h0);
    cycles(1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6.rst_req_valid", mem.req_valid, 32'd0);
    chk("t6.rst_pc_next", pc_next, RESET_PC);
    cycles(1);
    reset = 1'b0;
    @(negedge clk);
    chk("t6.after_rst_valid", ifid_valid, 32'd0);
    cycles(1);
    @(negedge clk);
    chk("t6.late_rsp_ignored", ifid_valid, 32'd0);
    wait_ifid("t6", 20);
    chk("t6.refetch_pc", ifid_pc, 32'h0);
    chk("t6.refetch_instr", ifid_instr, word_at(32'h0));

    cycles(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
